// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first, WIDTH cycles per operation.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             br_r;
    logic [CW-1:0]    cnt;

    logic             ai_c;
    logic             bi_c;
    logic             d_c;
    logic             br_next_c;
    logic [WIDTH-1:0] res_next_c;

    // Full-subtractor cell on the current bit, plus the shifted-in result word.
    always_comb begin
        ai_c       = a_r[cnt];
        bi_c       = b_r[cnt];
        d_c        = ai_c ^ bi_c ^ br_r;
        br_next_c  = (~ai_c & bi_c) | (~(ai_c ^ bi_c) & br_r);
        res_next_c = {d_c, res_r[WIDTH-1:1]};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            res_r    <= '0;
            br_r     <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.diff <= '0;
            bus.bout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r      <= bus.a;
                        b_r      <= bus.b;
                        br_r     <= bus.bin;
                        res_r    <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res_r <= res_next_c;
                    br_r  <= br_next_c;
                    if (cnt == CW'(MSB)) begin
                        // Last bit: publish the result including the bit computed this cycle.
                        bus.diff <= res_next_c;
                        bus.bout <= br_next_c;
                        bus.ovf  <= (a_r[MSB] ^ b_r[MSB]) & (d_c ^ a_r[MSB]);
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: table-driven WIDTH=8 vectors with a scoreboard, corner sequences,
// WIDTH=3 exhaustive back-to-back run and WIDTH=32 spot checks.
module tb_serial_subtractor;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  i8  ();
    serial_subtractor_if #(.WIDTH(3))  i3  ();
    serial_subtractor_if #(.WIDTH(32)) i32 ();

    serial_subtractor #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    serial_subtractor #(.WIDTH(3))  u3  (.clk(clk), .rst_n(rst_n), .bus(i3));
    serial_subtractor #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(i32));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    localparam int NV = 8;
    vec_t tbl [NV];
    exp_t sb8 [$];
    exp_t sb3 [$];
    exp_t e8;
    exp_t e3;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Arithmetic reference: widened subtraction, borrow is the bit above the result.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic bin);
        logic [63:0] full;
        logic [63:0] mask;
        exp_t        r;
        full = 64'(a) - 64'(b) - 64'(bin);
        mask = (64'd1 << w) - 64'd1;
        r.d  = 32'(full & mask);
        r.bo = full[w];
        r.ov = (a[w-1] ^ b[w-1]) & (r.d[w-1] ^ a[w-1]);
        return r;
    endfunction

    // Scoreboard for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (i8.done) begin
            chk("w8 done has pending op", 32'(sb8.size() > 0), 32'd1);
            if (sb8.size() > 0) begin
                e8 = sb8.pop_front();
                chk("w8 diff", 32'(i8.diff), e8.d);
                chk("w8 bout", 32'(i8.bout), 32'(e8.bo));
                chk("w8 ovf",  32'(i8.ovf),  32'(e8.ov));
            end
        end
    end

    // Scoreboard for the WIDTH=3 instance.
    always @(negedge clk) begin
        if (i3.done) begin
            chk("w3 done has pending op", 32'(sb3.size() > 0), 32'd1);
            if (sb3.size() > 0) begin
                e3 = sb3.pop_front();
                chk("w3 diff", 32'(i3.diff), e3.d);
                chk("w3 bout", 32'(i3.bout), 32'(e3.bo));
                chk("w3 ovf",  32'(i3.ovf),  32'(e3.ov));
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        @(posedge clk); #1;
        chk("w8 idle before start", 32'(i8.busy), 32'd0);
        i8.a = a; i8.b = b; i8.bin = bin; i8.start = 1'b1;
        sb8.push_back('{32'(ed), eb, eo});
        @(posedge clk); #1;
        i8.start = 1'b0;
        chk("w8 busy after accept", 32'(i8.busy), 32'd1);
        n = 0;
        while (!i8.done && n < 40) begin @(posedge clk); #1; n++; end
        chk("w8 done latency", 32'(n), 32'd8);
        @(posedge clk); #1;
        chk("w8 done single pulse", 32'(i8.done), 32'd0);
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic [31:0] ed, input logic eb, input logic eo);
        int n;
        @(posedge clk); #1;
        i32.a = a; i32.b = b; i32.bin = bin; i32.start = 1'b1;
        @(posedge clk); #1;
        i32.start = 1'b0;
        n = 0;
        while (!i32.done && n < 100) begin @(posedge clk); #1; n++; end
        chk("w32 done latency", 32'(n), 32'd32);
        chk("w32 diff", i32.diff, ed);
        chk("w32 bout", 32'(i32.bout), 32'(eb));
        chk("w32 ovf",  32'(i32.ovf),  32'(eo));
    endtask

    initial begin
        int n;
        int cyc;
        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tbl[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        tbl[5] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
        tbl[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

        i8.start  = 1'b0; i8.a  = '0; i8.b  = '0; i8.bin  = 1'b0;
        i3.start  = 1'b0; i3.a  = '0; i3.b  = '0; i3.bin  = 1'b0;
        i32.start = 1'b0; i32.a = '0; i32.b = '0; i32.bin = 1'b0;

        // Reset state, observed without any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("reset busy", 32'(i8.busy), 32'd0);
        chk("reset done", 32'(i8.done), 32'd0);
        chk("reset diff", 32'(i8.diff), 32'd0);
        chk("reset bout", 32'(i8.bout), 32'd0);
        chk("reset ovf",  32'(i8.ovf),  32'd0);
        chk("reset w32 diff", i32.diff, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++)
            op8(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo, tbl[i].ov);

        // Start re-asserted with new operands during RUN and DONE must be ignored.
        @(posedge clk); #1;
        i8.a = 8'h33; i8.b = 8'h11; i8.bin = 1'b0; i8.start = 1'b1;
        sb8.push_back('{32'h22, 1'b0, 1'b0});
        @(posedge clk); #1;
        i8.a = 8'hF0; i8.b = 8'h0F; i8.bin = 1'b1;
        n = 0;
        while (!i8.done && n < 40) begin
            chk("w8 diff held during RUN", 32'(i8.diff), 32'(tbl[NV-1].d));
            @(posedge clk); #1; n++;
        end
        chk("w8 latency with start held", 32'(n), 32'd8);
        @(posedge clk); #1;
        i8.start = 1'b0;
        chk("w8 start ignored in DONE", 32'(i8.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("w8 diff stable after DONE", 32'(i8.diff), 32'h22);

        // Reset while bit 3 is being processed aborts the operation.
        @(posedge clk); #1;
        i8.a = 8'h44; i8.b = 8'h01; i8.bin = 1'b0; i8.start = 1'b1;
        @(posedge clk); #1;
        i8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(i8.busy), 32'd0);
        chk("abort done", 32'(i8.done), 32'd0);
        chk("abort diff", 32'(i8.diff), 32'd0);
        chk("abort bout", 32'(i8.bout), 32'd0);
        chk("abort ovf",  32'(i8.ovf),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        i8.a = 8'h09; i8.b = 8'h04; i8.bin = 1'b0; i8.start = 1'b1;
        sb8.push_back('{32'h05, 1'b0, 1'b0});
        @(posedge clk); #1;
        i8.start = 1'b0;
        chk("start on first edge after reset", 32'(i8.busy), 32'd1);
        n = 0;
        while (!i8.done && n < 40) begin @(posedge clk); #1; n++; end
        chk("w8 latency after reset", 32'(n), 32'd8);
        @(posedge clk); #1;

        // WIDTH=3 exhaustive with start held high: one operation every WIDTH+2 cycles.
        cyc = 0;
        i3.start = 1'b1;
        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    i3.a = 3'(ia); i3.b = 3'(ib); i3.bin = 1'(ic);
                    sb3.push_back(model(3, 32'(ia), 32'(ib), 1'(ic)));
                    n = 0;
                    while (!i3.busy && n < 10) begin @(posedge clk); #1; n++; cyc++; end
                    n = 0;
                    while (i3.busy && n < 10) begin @(posedge clk); #1; n++; cyc++; end
                end
            end
        end
        i3.start = 1'b0;
        chk("w3 back-to-back cycle count", 32'(cyc), 32'(128 * 5));

        // WIDTH=32 spot checks.
        op32(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        op32(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        op32(32'h1234_5678, 32'h1234_5679, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op32(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        chk("w8 scoreboard drained", 32'(sb8.size()), 32'd0);
        chk("w3 scoreboard drained", 32'(sb3.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
